// File: rtl/snn_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snn_eval_sequencer
// Purpose  : Steps through NUM_SAMPLES stored vectors, applies each one to an
//            SNN core, scores the one-hot class result, and counts pass,
//            total and timeout. The optional confusion matrix is built when
//            SNN_EVAL_CONFUSION_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module snn_eval_sequencer #(
   parameter int NUM_FEATURES = 4,
   parameter int FEAT_W       = 8,
   parameter int NUM_CLASSES  = 3,
   parameter int NUM_SAMPLES  = 15,
   parameter int TIMEOUT_CYC  = 4096,
   parameter int GAP_CYC      = 10,
   localparam int CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   localparam int ADDR_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
   localparam int CNT_W  = $clog2(NUM_SAMPLES + 1),
   localparam int FV_W   = NUM_FEATURES * FEAT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic [ADDR_W-1:0]      rom_addr,
   input  logic [FV_W+CLS_W-1:0]  rom_data,
   output logic [FV_W-1:0]        feat_out,
   input  logic [NUM_CLASSES-1:0] core_class,
   input  logic                   core_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   sample_pass,
   output logic                   sample_fail,
   output logic [CNT_W-1:0]       correct_cnt,
   output logic [CNT_W-1:0]       total_cnt,
   output logic [CNT_W-1:0]       timeout_cnt
`ifdef SNN_EVAL_CONFUSION_EN
   ,
   input  logic [CLS_W-1:0]       conf_row,
   input  logic [CLS_W:0]         conf_col,
   output logic [CNT_W-1:0]       conf_cnt
`endif
);

   localparam int c_TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
   localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_GAP_LAST = c_TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [CNT_W-1:0]   c_CNT_MAX  = CNT_W'(NUM_SAMPLES);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_CHECK, S_GAP, S_FIN
   } state_t;

   state_t                 r_state, w_next;
   logic [c_TMR_W-1:0]     r_tmr;
   logic [CLS_W-1:0]       r_exp_idx;
   logic                   r_valid_q;
   logic                   w_edge, w_expired, w_score, w_gap_last, w_last;
   logic                   w_advance, w_idx_ok, w_pass;
   logic [NUM_CLASSES-1:0] w_exp_oh;

   assign w_edge     = core_valid & ~r_valid_q;
   assign w_expired  = (r_tmr == c_TO_LAST);
   assign w_score    = w_edge | w_expired;
   assign w_gap_last = (r_tmr == c_GAP_LAST);
   assign w_last     = (rom_addr == ADDR_W'(NUM_SAMPLES - 1));
   assign w_idx_ok   = ({1'b0, r_exp_idx} < (CLS_W+1)'(NUM_CLASSES));

   always_comb begin
      w_exp_oh = '0;
      for (int i = 0; i < NUM_CLASSES; i++)
         w_exp_oh[i] = (r_exp_idx == CLS_W'(i));
   end

   // A timed-out sample never passes; an edge on the expiry cycle is a real result.
   assign w_pass = w_edge & w_idx_ok & (core_class == w_exp_oh);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_advance = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = S_FETCH;
         S_FETCH: w_next = S_LOAD;
         S_LOAD:  w_next = S_WAIT;
         S_WAIT:  if (w_score) w_next = S_CHECK;
         S_CHECK: if (GAP_CYC == 0) w_advance = 1'b1;
                  else              w_next    = S_GAP;
         S_GAP:   if (w_gap_last) w_advance = 1'b1;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_advance) w_next = w_last ? S_FIN : S_FETCH;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_addr    <= '0;
         feat_out    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         sample_pass <= 1'b0;
         sample_fail <= 1'b0;
         correct_cnt <= '0;
         total_cnt   <= '0;
         timeout_cnt <= '0;
         r_tmr       <= '0;
         r_exp_idx   <= '0;
         r_valid_q   <= 1'b0;
      end else begin
         r_valid_q   <= core_valid;
         sample_pass <= 1'b0;
         sample_fail <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               correct_cnt <= '0;
               total_cnt   <= '0;
               timeout_cnt <= '0;
               done        <= 1'b0;
               busy        <= 1'b1;
               rom_addr    <= '0;
            end
            S_LOAD: begin
               feat_out  <= rom_data[FV_W-1:0];
               r_exp_idx <= rom_data[FV_W +: CLS_W];
               r_tmr     <= '0;
            end
            S_WAIT: if (w_score) begin
               // Score lands with the CHECK cycle so strobes and counters align.
               sample_pass <= w_pass;
               sample_fail <= ~w_pass;
               r_tmr       <= '0;
               if (total_cnt != c_CNT_MAX) total_cnt <= total_cnt + CNT_W'(1);
               if (w_pass && correct_cnt != c_CNT_MAX)
                  correct_cnt <= correct_cnt + CNT_W'(1);
               if (!w_edge && timeout_cnt != c_CNT_MAX)
                  timeout_cnt <= timeout_cnt + CNT_W'(1);
            end else begin
               r_tmr <= r_tmr + c_TMR_W'(1);
            end
            S_GAP:   r_tmr <= r_tmr + c_TMR_W'(1);
            default: ;
         endcase
         if (w_advance) begin
            if (w_last) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               rom_addr <= rom_addr + ADDR_W'(1);
            end
         end
      end
   end

`ifdef SNN_EVAL_CONFUSION_EN
   logic [CNT_W-1:0] r_conf [NUM_CLASSES][NUM_CLASSES+1];
   logic [CLS_W:0]   w_col;
   logic [CNT_W-1:0] w_conf_rd;

   // Column NUM_CLASSES collects timeouts, zero and multi-hot results.
   always_comb begin
      w_col = (CLS_W+1)'(NUM_CLASSES);
      for (int i = 0; i < NUM_CLASSES; i++)
         if (w_edge && core_class == (NUM_CLASSES'(1) << i)) w_col = (CLS_W+1)'(i);
   end

   always_comb begin
      w_conf_rd = '0;
      for (int r = 0; r < NUM_CLASSES; r++)
         for (int c = 0; c <= NUM_CLASSES; c++)
            if (conf_row == CLS_W'(r) && conf_col == (CLS_W+1)'(c)) w_conf_rd = r_conf[r][c];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_CLASSES; r++)
            for (int c = 0; c <= NUM_CLASSES; c++)
               r_conf[r][c] <= '0;
         conf_cnt <= '0;
      end else begin
         conf_cnt <= w_conf_rd;
         for (int r = 0; r < NUM_CLASSES; r++)
            for (int c = 0; c <= NUM_CLASSES; c++) begin
               if (r_state == S_IDLE && start)
                  r_conf[r][c] <= '0;
               else if (r_state == S_WAIT && w_score && w_idx_ok &&
                        r_exp_idx == CLS_W'(r) && w_col == (CLS_W+1)'(c) &&
                        r_conf[r][c] != c_CNT_MAX)
                  r_conf[r][c] <= r_conf[r][c] + CNT_W'(1);
            end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_eval_sequencer
// Purpose  : Directed self-checking bench with a ROM model and a behavioural
//            core whose response mode is selected per scenario.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_snn_eval_sequencer;
   localparam int NF = 4, FW = 8, NC = 3, NS = 15, TO = 32, GAP = 2;
   localparam int CLS_W = 2, ADDR_W = 4, CNT_W = 4, DW = NF*FW + CLS_W;
   localparam int LAT = 20;

   logic              clk = 1'b0;
   logic              reset, start;
   logic [ADDR_W-1:0] rom_addr;
   logic [DW-1:0]     rom_data;
   logic [NF*FW-1:0]  feat_out;
   logic [NC-1:0]     core_class = '0;
   logic              core_valid = 1'b0;
   logic              busy, done, sample_pass, sample_fail;
   logic [CNT_W-1:0]  correct_cnt, total_cnt, timeout_cnt;
`ifdef SNN_EVAL_CONFUSION_EN
   logic [CLS_W-1:0]  conf_row = '0;
   logic [CLS_W:0]    conf_col = '0;
   logic [CNT_W-1:0]  conf_cnt;
`endif

   int checks = 0, errors = 0;
   int pass_pulses = 0, fail_pulses = 0;
   int core_mode = 0;
   logic [NC-1:0] fixed_class = '0;
   int cnt = 0;
   logic [NF*FW-1:0] last_feat = '0;
   logic [DW-1:0] rom_mem [16];

   snn_eval_sequencer #(
      .NUM_FEATURES(NF), .FEAT_W(FW), .NUM_CLASSES(NC), .NUM_SAMPLES(NS),
      .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
      .feat_out(feat_out), .core_class(core_class), .core_valid(core_valid),
      .busy(busy), .done(done), .sample_pass(sample_pass), .sample_fail(sample_fail),
      .correct_cnt(correct_cnt), .total_cnt(total_cnt), .timeout_cnt(timeout_cnt)
`ifdef SNN_EVAL_CONFUSION_EN
      , .conf_row(conf_row), .conf_col(conf_col), .conf_cnt(conf_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   always @(negedge clk) begin
      if (sample_pass) pass_pulses++;
      if (sample_fail) fail_pulses++;
   end

   // Core model: mode 0 echoes class, 1 fixed class, 2 silent, 3 level-held valid.
   always @(negedge clk) begin
      logic [3:0] oh;
      if (feat_out != last_feat) begin
         last_feat = feat_out;
         oh = 4'd1 << feat_out[9:8];
         core_class = (core_mode == 1) ? fixed_class : oh[2:0];
         if (core_mode <= 1) begin
            core_valid = 1'b0; cnt = LAT;
         end else if (core_mode == 2) begin
            core_valid = 1'b0; cnt = 0;
         end else if (((feat_out[7:0] - 8'd1) & 8'd1) == 8'd0) begin
            core_valid = 1'b0; cnt = TO - 1;
         end else begin
            cnt = 0;
         end
      end else if (cnt != 0) begin
         cnt--;
         if (cnt == 0) core_valid = 1'b1;
      end else if (core_mode != 3) begin
         core_valid = 1'b0;
      end
   end

   // pat: 0 = i%3, 1 = i/5, 2 = all zero, 3 = out-of-range idx for samples 0..2
   task automatic load_rom(input int pat);
      for (int i = 0; i < 16; i++) begin
         int cls;
         case (pat)
            0: cls = i % 3;
            1: cls = i / 5;
            2: cls = 0;
            default: cls = (i < 3) ? 3 : i % 3;
         endcase
         rom_mem[i] = {CLS_W'(cls), 8'hA5, 8'(i*3), 8'(cls), 8'(i+1)};
      end
   endtask

   task automatic begin_run(input string nm);
      pass_pulses = 0; fail_pulses = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
         $display("FAIL %s_start: busy=%b done=%b want busy=1 done=0", nm, busy, done); end
   endtask

   task automatic wait_done(input string nm, input bit poke_start);
      int n = 0;
      while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      checks++; if (done !== 1'b1) begin errors++;
         $display("FAIL %s_done: done=%b after %0d cycles want 1", nm, done, n); end
      if (poke_start) begin
         start = 1'b1; @(negedge clk); start = 1'b0;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic measure_lat(input string nm, input int want);
      logic [NF*FW-1:0] prior = feat_out;
      int n = 0;
      while (feat_out == prior && n < 50) begin @(negedge clk); n++; end
      n = 0;
      while (!(sample_pass || sample_fail) && n < 200) begin @(negedge clk); n++; end
      checks++; if (n !== want) begin errors++;
         $display("FAIL %s_latency: got %0d cycles want %0d", nm, n, want); end
   endtask

   task automatic check_counts(input string nm, input int tot, input int cor, input int tmo,
                               input int pp, input int fp);
      checks++; if (total_cnt !== CNT_W'(tot)) begin errors++;
         $display("FAIL %s_total: got %0d want %0d", nm, total_cnt, tot); end
      checks++; if (correct_cnt !== CNT_W'(cor)) begin errors++;
         $display("FAIL %s_correct: got %0d want %0d", nm, correct_cnt, cor); end
      checks++; if (timeout_cnt !== CNT_W'(tmo)) begin errors++;
         $display("FAIL %s_timeout: got %0d want %0d", nm, timeout_cnt, tmo); end
      checks++; if (pass_pulses !== pp || fail_pulses !== fp) begin errors++;
         $display("FAIL %s_pulses: pass=%0d fail=%0d want %0d/%0d", nm, pass_pulses, fail_pulses, pp, fp); end
      checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++;
         $display("FAIL %s_end: busy=%b done=%b want 0/1", nm, busy, done); end
   endtask

`ifdef SNN_EVAL_CONFUSION_EN
   task automatic check_conf(input string nm, input int r, input int c, input int want);
      @(negedge clk); conf_row = CLS_W'(r); conf_col = (CLS_W+1)'(c);
      @(negedge clk);
      checks++; if (conf_cnt !== CNT_W'(want)) begin errors++;
         $display("FAIL %s_conf[%0d][%0d]: got %0d want %0d", nm, r, c, conf_cnt, want); end
   endtask
`endif

   task automatic test_reset();
      #1;
      checks++; if (busy !== 0 || done !== 0 || sample_pass !== 0 || sample_fail !== 0) begin errors++;
         $display("FAIL reset_flags: busy=%b done=%b pass=%b fail=%b want 0", busy, done, sample_pass, sample_fail); end
      checks++; if (total_cnt !== 0 || correct_cnt !== 0 || timeout_cnt !== 0) begin errors++;
         $display("FAIL reset_counts: %0d/%0d/%0d want 0", total_cnt, correct_cnt, timeout_cnt); end
      checks++; if (rom_addr !== 0 || feat_out !== 0) begin errors++;
         $display("FAIL reset_addr_feat: addr=%0d feat=%h want 0", rom_addr, feat_out); end
   endtask

   task automatic test_ideal();
      core_mode = 0; load_rom(0);
      begin_run("t1");
      measure_lat("t1", LAT + 1);
      wait_done("t1", 0);
      check_counts("t1", 15, 15, 0, 15, 0);
      checks++; if (rom_addr !== 4'd14 || feat_out[7:0] !== 8'd15) begin errors++;
         $display("FAIL t1_hold: addr=%0d f0=%0d want 14/15", rom_addr, feat_out[7:0]); end
   endtask

   task automatic test_fixed_class();
      core_mode = 1; fixed_class = 3'b001; load_rom(1);
      begin_run("t2");
      wait_done("t2", 0);
      check_counts("t2", 15, 5, 0, 5, 10);
`ifdef SNN_EVAL_CONFUSION_EN
      check_conf("t2", 1, 0, 5);
      check_conf("t2", 2, 0, 5);
      check_conf("t2", 0, 1, 0);
`endif
   endtask

   task automatic test_timeout();
      core_mode = 2; load_rom(0);
      begin_run("t3");
      measure_lat("t3", TO);
      wait_done("t3", 0);
      check_counts("t3", 15, 0, 15, 0, 15);
   endtask

   task automatic test_held_valid();
      core_mode = 3; load_rom(0);
      begin_run("t4");
      wait_done("t4", 0);
      check_counts("t4", 15, 8, 7, 8, 7);
   endtask

   task automatic test_reset_mid_run();
      int n = 0;
      core_mode = 0; load_rom(0);
      begin_run("t5");
      while (feat_out[7:0] !== 8'd8 && n < 1000) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      checks++; if (total_cnt !== 4'd7) begin errors++;
         $display("FAIL t5_before_reset: total=%0d want 7", total_cnt); end
      reset = 1'b1; #1;
      checks++; if (busy !== 0 || done !== 0 || total_cnt !== 0 || correct_cnt !== 0 || rom_addr !== 0) begin errors++;
         $display("FAIL t5_async_reset: busy=%b done=%b total=%0d correct=%0d addr=%0d want 0",
                  busy, done, total_cnt, correct_cnt, rom_addr); end
      @(negedge clk); reset = 1'b0;
      begin_run("t5b");
      wait_done("t5b", 0);
      check_counts("t5b", 15, 15, 0, 15, 0);
   endtask

   task automatic test_start_ignored();
      core_mode = 1; fixed_class = 3'b011; load_rom(2);
      begin_run("t6");
      repeat (30) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (100) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_done("t6", 1);
      check_counts("t6", 15, 0, 0, 0, 15);
`ifdef SNN_EVAL_CONFUSION_EN
      check_conf("t6", 0, 3, 15);
`endif
   endtask

   task automatic test_out_of_range();
      core_mode = 0; load_rom(3);
      begin_run("t7");
      wait_done("t7", 0);
      check_counts("t7", 15, 12, 0, 12, 3);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      load_rom(0);
      test_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_ideal();
      test_fixed_class();
      test_timeout();
      test_held_valid();
      test_reset_mid_run();
      test_start_ignored();
      test_out_of_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
